// File: rtl/cpu_types_pkg.sv
// Shared CPU types: bus word and the MEM-stage request controller state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } memctl_state_t;

endpackage

// File: rtl/mem_request_ctrl.sv
// MEM-stage dcache request controller: one request per instruction, 1 cycle + cache latency to hit.
// Stalls the pipeline until dhit; a hit without advance is parked in DONE until the latches move.
module mem_request_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN_in,
  input  logic        dWEN_in,
  input  word_t       addr_in,
  input  word_t       store_in,
  input  logic        HALT_in,
  input  logic        advance,
  input  logic        dhit,
  input  word_t       dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output word_t       dmemaddr,
  output word_t       dmemstore,
  output word_t       load_data,
  output logic        load_valid,
  output logic        mem_stall,
  output logic        misalign,
  output logic        halt_out,
  output logic [15:0] req_count
);

  memctl_state_t state, next_state;
  word_t         hold;
  logic [15:0]   count;
  logic          req_any, req_pend, is_load, unaligned;

  assign req_any   = dREN_in | dWEN_in;
  assign req_pend  = req_any & ~halt_out;
  assign is_load   = dREN_in & ~dWEN_in;
  assign unaligned = |addr_in[1:0];
  assign req_count = count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_pend) next_state = REQ;
      REQ:     if (dhit) next_state = advance ? IDLE : DONE;
      DONE:    if (advance) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hold     <= '0;
      count    <= '0;
      halt_out <= 1'b0;
    end else begin
      if (state == REQ && dhit) begin
        hold  <= dmemload;
        count <= count + 16'd1;
      end
      // Halt only latches between memory instructions so an in-flight access is never cut short.
      if (state == IDLE && HALT_in && !req_any) halt_out <= 1'b1;
    end
  end

  // Outputs read zero for as long as reset is held, even the pass-through buses.
  always_comb begin
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    dmemaddr   = '0;
    dmemstore  = '0;
    load_data  = '0;
    load_valid = 1'b0;
    mem_stall  = 1'b0;
    misalign   = 1'b0;
    if (nRST) begin
      dmemaddr  = {addr_in[31:2], 2'b00};
      dmemstore = store_in;
      case (state)
        IDLE: begin
          mem_stall = req_pend;
          misalign  = req_pend & unaligned;
        end
        REQ: begin
          dmemREN   = is_load;
          dmemWEN   = dWEN_in;
          mem_stall = ~dhit;
          misalign  = req_any & unaligned;
          if (dhit) begin
            load_data  = dmemload;
            load_valid = is_load;
          end
        end
        DONE: begin
          load_data  = hold;
          load_valid = is_load;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_ctrl.sv
// Randomized scoreboard bench for mem_request_ctrl with directed corner cases.
module tb_mem_request_ctrl;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dREN_in, dWEN_in, HALT_in, advance, dhit;
  word_t       addr_in, store_in, dmemload;
  logic        dmemREN, dmemWEN, load_valid, mem_stall, misalign, halt_out;
  word_t       dmemaddr, dmemstore, load_data;
  logic [15:0] req_count;

  mem_request_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .dREN_in(dREN_in), .dWEN_in(dWEN_in), .addr_in(addr_in), .store_in(store_in),
    .HALT_in(HALT_in), .advance(advance), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .load_data(load_data), .load_valid(load_valid), .mem_stall(mem_stall),
    .misalign(misalign), .halt_out(halt_out), .req_count(req_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic  st;
    word_t addr;
    word_t sdat;
    word_t ldat;
  } exp_t;

  exp_t  expq[$];
  exp_t  e;
  int    checks = 0;
  int    failures = 0;
  int    model_count = 0;
  word_t last_load = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cache handshake is one completed transaction and must match the scoreboard head.
  always @(negedge CLK) begin
    if (nRST) begin
      if ((dmemREN | dmemWEN) && dhit) begin
        if (expq.size() == 0) begin
          chk("unexpected_req", 32'(dmemREN | dmemWEN), 32'd0);
        end else begin
          e = expq.pop_front();
          chk("sb_wen", 32'(dmemWEN), 32'(e.st));
          chk("sb_ren", 32'(dmemREN), 32'(!e.st));
          chk("sb_addr", dmemaddr, e.addr);
          chk("sb_lvalid", 32'(load_valid), 32'(!e.st));
          if (e.st) chk("sb_sdat", dmemstore, e.sdat);
          else begin
            chk("sb_ldat", load_data, e.ldat);
            last_load = e.ldat;
          end
        end
      end else if (load_valid) begin
        chk("sb_held", load_data, last_load);
      end
    end
  end

  // Drives one memory instruction from IDLE: cache answers after lat cycles, latch advances hold_cyc cycles later.
  task automatic run_txn(input logic ren, input logic wen, input word_t addr, input word_t sdat,
                         input word_t ldat, input int lat, input int hold_cyc);
    exp_t x;
    dREN_in = ren; dWEN_in = wen; addr_in = addr; store_in = sdat;
    dhit = 1'b0; advance = 1'b0; HALT_in = 1'b0;
    x.st = wen; x.addr = addr & 32'hFFFF_FFFC; x.sdat = sdat; x.ldat = ldat;
    expq.push_back(x);
    @(negedge CLK);
    chk("idle_stall", 32'(mem_stall), 32'd1);
    chk("idle_noreq", 32'(dmemREN | dmemWEN), 32'd0);
    chk("misalign", 32'(misalign), 32'(addr[1:0] != 2'b00));
    @(posedge CLK); #1;
    for (int k = 1; k <= lat; k++) begin
      dhit     = (k == lat);
      dmemload = (k == lat) ? ldat : $urandom;
      advance  = (k == lat) && (hold_cyc == 0);
      @(negedge CLK);
      chk("req_stall", 32'(mem_stall), 32'(k != lat));
      chk("req_active", 32'(dmemREN | dmemWEN), 32'd1);
      @(posedge CLK); #1;
    end
    dhit = 1'b0;
    dmemload = $urandom;
    for (int k = 0; k < hold_cyc; k++) begin
      advance = (k == hold_cyc - 1);
      @(negedge CLK);
      chk("done_quiet", 32'(dmemREN | dmemWEN | mem_stall), 32'd0);
      chk("done_valid", 32'(load_valid), 32'(ren & ~wen));
      chk("done_data", load_data, ldat);
      @(posedge CLK); #1;
    end
    advance = 1'b0;
    dREN_in = 1'b0; dWEN_in = 1'b0;
    model_count++;
    chk("count", 32'(req_count), 32'(model_count[15:0]));
  endtask

  initial begin
    nRST = 1'b0;
    dREN_in = 1'b1; dWEN_in = 1'b0; addr_in = 32'h107; store_in = 32'hCAFE_F00D;
    HALT_in = 1'b0; advance = 1'b0; dhit = 1'b1; dmemload = 32'h1111_2222;
    #12;
    chk("rst_ren", 32'(dmemREN | dmemWEN), 32'd0);
    chk("rst_addr", dmemaddr, 32'd0);
    chk("rst_store", dmemstore, 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    chk("rst_misc", 32'({load_valid, mem_stall, misalign, halt_out}), 32'd0);
    chk("rst_count", 32'(req_count), 32'd0);
    dREN_in = 1'b0; dhit = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;

    run_txn(1'b1, 1'b0, 32'h104, $urandom, 32'hDEAD_BEEF, 3, 0);
    run_txn(1'b0, 1'b1, 32'h200, 32'h1234_5678, $urandom, 1, 0);
    run_txn(1'b1, 1'b0, 32'h300, $urandom, 32'hA5A5_A5A5, 1, 2);
    run_txn(1'b1, 1'b0, 32'h107, $urandom, $urandom, 2, 0);
    run_txn(1'b1, 1'b1, 32'h40C, 32'h0BAD_CAFE, $urandom, 2, 1);

    for (int n = 0; n < 200; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 3) begin
        dREN_in = 1'b0; dWEN_in = 1'b0;
        @(negedge CLK);
        chk("gap_quiet", 32'(dmemREN | dmemWEN | mem_stall), 32'd0);
        @(posedge CLK); #1;
      end
      run_txn(kind != 1, kind != 0, $urandom, $urandom, $urandom,
              $urandom_range(1, 4), $urandom_range(0, 3));
    end

    // Reset in the middle of an outstanding load.
    dREN_in = 1'b1; addr_in = 32'h500;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("midreq_active", 32'(dmemREN), 32'd1);
    #1 nRST = 1'b0;
    #1;
    chk("midreq_drop", 32'(dmemREN | dmemWEN), 32'd0);
    chk("midreq_count", 32'(req_count), 32'd0);
    dREN_in = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    model_count = 0;
    @(posedge CLK); #1;

    HALT_in = 1'b1;
    @(posedge CLK); #1;
    HALT_in = 1'b0;
    chk("halt_set", 32'(halt_out), 32'd1);
    dREN_in = 1'b1; addr_in = 32'h600;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("halt_noreq", 32'({dmemREN, dmemWEN, mem_stall}), 32'd0);
      chk("halt_sticky", 32'(halt_out), 32'd1);
    end
    dREN_in = 1'b0;
    @(negedge CLK); nRST = 1'b0;
    #1 chk("halt_cleared", 32'(halt_out), 32'd0);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;

    // Counter preloaded to the value left by 65535 completions, then one more must wrap.
    force dut.count = 16'hFFFF;
    #1 release dut.count;
    @(posedge CLK); #1;
    chk("preload", 32'(req_count), 32'h0000_FFFF);
    model_count = 65535;
    run_txn(1'b0, 1'b1, 32'h700, $urandom, $urandom, 1, 0);
    chk("wrap", 32'(req_count), 32'd0);

    @(posedge CLK); #1;
    chk("sb_drain", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
